// File: rtl/aes_tx_framer.sv
// Buffers 128-bit AES result blocks and sends each one as an 18-byte UART frame: tag, 16 data bytes MSB first, XOR checksum.
// First tx_flag comes 2 edges after the push into an idle, empty stage. blk_ready drops when the FIFO is full. Bytes are paced by tx_end, with a per-byte timeout.
module aes_tx_framer #(
   parameter int          DEPTH      = 2,
   parameter int          TX_TIMEOUT = 100_000,
   parameter logic [7:0]  TAG_CIPHER = 8'h43,
   parameter logic [7:0]  TAG_PLAIN  = 8'h50
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         blk_valid,
   output logic         blk_ready,
   input  logic [127:0] blk_data,
   input  logic         blk_type,
   output logic [7:0]   tx_data,
   output logic         tx_flag,
   input  logic         tx_end,
   output logic         busy,
   output logic         frame_done,
   output logic         tx_err
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int TW = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL     = CW'(DEPTH);
   localparam logic [TW-1:0] TMO_LAST = TW'(TX_TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, DONE} state_t;

   // Entry layout: bit 128 = type (1 = plain), bits 127:0 = data.
   logic [128:0]   mem [DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [CW-1:0]  count;
   logic           push;
   logic           pop;

   state_t         state;
   state_t         state_nxt;
   logic [127:0]   shreg;
   logic [7:0]     chk;
   logic [7:0]     head_chk;
   logic [4:0]     idx;
   logic [TW-1:0]  tmr;
   logic           expire;

   assign blk_ready = (count != FULL);
   assign push      = blk_valid && blk_ready;
   assign pop       = (state == LOAD);
   assign busy      = (state != IDLE);
   assign expire    = (state == WAIT) && !tx_end && (tmr == TMO_LAST);

   always_comb begin
      head_chk = '0;
      for (int i = 0; i < 16; i++) begin
         head_chk = head_chk ^ mem[rd_ptr][i*8 +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {blk_type, blk_data};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (count != '0) state_nxt = LOAD;
         LOAD:    state_nxt = SEND;
         SEND:    state_nxt = WAIT;
         WAIT: begin
            // A completed byte wins over a timeout landing on the same edge.
            if (tx_end) begin
               state_nxt = (idx == 5'd17) ? DONE : SEND;
            end else if (tmr == TMO_LAST) begin
               state_nxt = IDLE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // tx_data/tx_flag are registered, so the byte is chosen on the edge that enters SEND.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shreg      <= '0;
         chk        <= '0;
         idx        <= '0;
         tmr        <= '0;
         tx_data    <= '0;
         tx_flag    <= 1'b0;
         frame_done <= 1'b0;
         tx_err     <= 1'b0;
      end else begin
         tx_flag    <= (state_nxt == SEND);
         frame_done <= (state_nxt == DONE);
         tx_err     <= expire;
         case (state)
            LOAD: begin
               shreg   <= mem[rd_ptr][127:0];
               chk     <= head_chk;
               idx     <= '0;
               tx_data <= mem[rd_ptr][128] ? TAG_PLAIN : TAG_CIPHER;
            end
            SEND: tmr <= '0;
            WAIT: begin
               if (tx_end) begin
                  if (idx != 5'd17) begin
                     idx <= idx + 5'd1;
                     if (idx == 5'd16) begin
                        tx_data <= chk;
                     end else begin
                        tx_data <= shreg[127:120];
                        shreg   <= {shreg[119:0], 8'h00};
                     end
                  end
               end else if (!expire) begin
                  tmr <= tmr + TW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_tx_framer.sv
// Self-checking bench for aes_tx_framer: frame vectors, back-pressure, timeout, stray tx_end, mid-frame reset, random traffic.
module tb_aes_tx_framer;

   localparam int DEPTH = 2;
   localparam int TMO   = 64;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         blk_valid = 1'b0;
   logic         blk_ready;
   logic [127:0] blk_data = '0;
   logic         blk_type = 1'b0;
   logic [7:0]   tx_data;
   logic         tx_flag;
   logic         tx_end;
   logic         busy;
   logic         frame_done;
   logic         tx_err;
   logic         auto_end = 1'b0;
   logic         man_end = 1'b0;

   assign tx_end = auto_end | man_end;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int n_flag = 0;
   int n_done = 0;
   int n_err = 0;
   int last_err_cyc = 0;
   int resp_delay = 0;
   int cd = 0;
   int acc_cyc = 0;
   int last_wait = 0;
   logic [7:0] rx_q[$];
   int         flag_cyc_q[$];
   logic [7:0] exp_q[$];

   typedef struct {
      logic         t;
      logic [127:0] d;
      int           dly;
      logic [7:0]   tag;
      logic [7:0]   chk;
      logic [7:0]   b1;
   } vec_t;
   vec_t vt[5];

   aes_tx_framer #(.DEPTH(DEPTH), .TX_TIMEOUT(TMO), .TAG_CIPHER(8'h43), .TAG_PLAIN(8'h50)) dut (
      .clk(clk), .rst_n(rst_n), .blk_valid(blk_valid), .blk_ready(blk_ready),
      .blk_data(blk_data), .blk_type(blk_type), .tx_data(tx_data), .tx_flag(tx_flag),
      .tx_end(tx_end), .busy(busy), .frame_done(frame_done), .tx_err(tx_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor plus UART model: tx_end comes resp_delay cycles after each tx_flag (0 = never).
   always begin
      @(posedge clk);
      #2;
      if (rst_n) begin
         if (tx_flag) begin
            rx_q.push_back(tx_data);
            flag_cyc_q.push_back(cyc);
            n_flag++;
         end
         if (frame_done) n_done++;
         if (tx_err) begin
            n_err++;
            last_err_cyc = cyc;
         end
      end
      auto_end = 1'b0;
      if (cd > 0) begin
         cd--;
         if (cd == 0) auto_end = 1'b1;
      end
      if (tx_flag && resp_delay > 0) cd = resp_delay;
   end

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic void add_frame(input logic t, input logic [127:0] d);
      logic [7:0] b;
      logic [7:0] c;
      c = 8'h00;
      exp_q.push_back(t ? 8'h50 : 8'h43);
      for (int i = 0; i < 16; i++) begin
         b = 8'((d >> (8 * (15 - i))) & 128'hff);
         c = c ^ b;
         exp_q.push_back(b);
      end
      exp_q.push_back(c);
   endfunction

   function automatic logic [7:0] rxb(input int i);
      return (i < rx_q.size()) ? rx_q[i] : 8'hxx;
   endfunction

   function automatic int fcyc(input int i);
      return (i < flag_cyc_q.size()) ? flag_cyc_q[i] : -1000;
   endfunction

   task automatic push_blk(input logic t, input logic [127:0] d);
      blk_valid = 1'b1;
      blk_type  = t;
      blk_data  = d;
      last_wait = 0;
      for (int k = 0; k < 400 && !blk_ready; k++) begin
         @(negedge clk);
         last_wait++;
      end
      check("push_accept", blk_ready, 1'b1);
      acc_cyc = cyc + 1;
      add_frame(t, d);
      @(negedge clk);
      blk_valid = 1'b0;
      blk_data  = {$urandom, $urandom, $urandom, $urandom};
      blk_type  = ~t;
   endtask

   task automatic wait_done(input string nm, input int target, input int budget);
      for (int k = 0; k < budget && n_done < target; k++) @(negedge clk);
      repeat (2) @(negedge clk);
      check(nm, n_done, target);
   endtask

   task automatic cmp_frames(input string nm, input int base);
      check({nm, "_len"}, rx_q.size() - base, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         check($sformatf("%s_byte%0d", nm, i), rxb(base + i), exp_q[i]);
      end
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      blk_valid  = 1'b0;
      man_end    = 1'b0;
      resp_delay = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int rb, fb, db, eb, seen;

      vt[0] = '{1'b0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 10, 8'h43, 8'hc9, 8'h69};
      vt[1] = '{1'b1, 128'h0, 1, 8'h50, 8'h00, 8'h00};
      vt[2] = '{1'b0, {128{1'b1}}, 1, 8'h43, 8'h00, 8'hff};
      vt[3] = '{1'b1, 128'h0102030405060708090a0b0c0d0e0f10, 3, 8'h50, 8'h10, 8'h01};
      vt[4] = '{1'b0, 128'ha5, 2, 8'h43, 8'ha5, 8'h00};

      do_reset();
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_tx_flag", tx_flag, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_blk_ready", blk_ready, 1'b1);
      check("rst_frame_done", frame_done, 1'b0);
      check("rst_tx_err", tx_err, 1'b0);

      // Table-driven single frames.
      for (int i = 0; i < 5; i++) begin
         resp_delay = vt[i].dly;
         rb = rx_q.size(); fb = n_flag; db = n_done; eb = n_err;
         exp_q.delete();
         push_blk(vt[i].t, vt[i].d);
         wait_done($sformatf("vec%0d_done", i), db + 1, 3000);
         check($sformatf("vec%0d_tag", i), rxb(rb), vt[i].tag);
         check($sformatf("vec%0d_b1", i), rxb(rb + 1), vt[i].b1);
         check($sformatf("vec%0d_chk", i), rxb(rb + 17), vt[i].chk);
         check($sformatf("vec%0d_flags", i), n_flag - fb, 18);
         check($sformatf("vec%0d_err", i), n_err - eb, 0);
         check($sformatf("vec%0d_latency", i), fcyc(rb) - acc_cyc, 2);
         if (vt[i].dly == 1) check($sformatf("vec%0d_spacing", i), fcyc(rb + 1) - fcyc(rb), 2);
         cmp_frames($sformatf("vec%0d", i), rb);
      end

      // Back-pressure: A, B, C offered with blk_valid held high.
      resp_delay = 1;
      rb = rx_q.size(); fb = n_flag; db = n_done; eb = n_err;
      exp_q.delete();
      push_blk(1'b0, 128'haaaa_0000_1111_2222_3333_4444_5555_6666);
      check("bp_a_latency_base", last_wait, 0);
      seen = acc_cyc;
      push_blk(1'b1, 128'hbbbb_7777_8888_9999_aaaa_bbbb_cccc_dddd);
      check("bp_b_accept", acc_cyc, seen + 1);
      push_blk(1'b0, 128'hcccc_eeee_ffff_0123_4567_89ab_cdef_0f0f);
      check("bp_c_stall", last_wait, 1);
      check("bp_c_after_pop", acc_cyc, fcyc(rb) + 1);
      check("bp_a_latency", fcyc(rb) - seen, 2);
      wait_done("bp_done", db + 3, 3000);
      check("bp_flags", n_flag - fb, 54);
      check("bp_err", n_err - eb, 0);
      check("bp_gap", fcyc(rb + 18) - fcyc(rb + 17), 5);
      cmp_frames("bp", rb);

      // Timeout on the tag byte, then the queued block runs as a fresh frame.
      resp_delay = 0;
      rb = rx_q.size(); fb = n_flag; db = n_done; eb = n_err;
      exp_q.delete();
      push_blk(1'b0, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0);
      while (exp_q.size() > 1) void'(exp_q.pop_back());
      push_blk(1'b1, 128'h1234_5678_9abc_def0_1357_9bdf_2468_ace0);
      for (int k = 0; k < 300 && n_err == eb; k++) @(negedge clk);
      resp_delay = 1;
      check("tmo_err", n_err - eb, 1);
      check("tmo_err_time", last_err_cyc - fcyc(rb), TMO + 1);
      check("tmo_busy_low", busy, 1'b0);
      wait_done("tmo_done", db + 1, 3000);
      check("tmo_flags", n_flag - fb, 19);
      check("tmo_err_once", n_err - eb, 1);
      check("tmo_restart", fcyc(rb + 1) - last_err_cyc, 2);
      cmp_frames("tmo", rb);

      // Stray tx_end in SEND, then tx_end coinciding with timeout expiry.
      resp_delay = 0;
      rb = rx_q.size(); fb = n_flag; db = n_done; eb = n_err;
      exp_q.delete();
      push_blk(1'b1, 128'hfedcba9876543210_0123456789abcdef);
      for (int k = 0; k < 20 && !tx_flag; k++) @(negedge clk);
      check("stray_first_flag", tx_flag, 1'b1);
      man_end = 1'b1;
      @(negedge clk);
      man_end = 1'b0;
      repeat (3) @(negedge clk);
      check("stray_ignored", n_flag - fb, 1);
      man_end = 1'b1;
      @(negedge clk);
      man_end = 1'b0;
      check("stray_flag2", tx_flag, 1'b1);
      check("stray_index", tx_data, 8'hfe);
      repeat (TMO) @(negedge clk);
      resp_delay = 1;
      man_end = 1'b1;
      @(negedge clk);
      man_end = 1'b0;
      check("simul_flag3", tx_flag, 1'b1);
      check("simul_byte", tx_data, 8'hdc);
      wait_done("simul_done", db + 1, 3000);
      check("simul_no_err", n_err - eb, 0);
      check("simul_flags", n_flag - fb, 18);
      cmp_frames("simul", rb);

      // Reset mid-frame with one entry still queued.
      resp_delay = 1;
      push_blk(1'b0, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
      push_blk(1'b1, 128'h9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0000);
      seen = 0;
      for (int k = 0; k < 200 && seen < 6; k++) begin
         @(negedge clk);
         if (tx_flag) seen++;
      end
      check("mrst_reached", seen, 6);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("mrst_tx_data", tx_data, 8'h00);
      check("mrst_tx_flag", tx_flag, 1'b0);
      check("mrst_busy", busy, 1'b0);
      check("mrst_done", frame_done, 1'b0);
      check("mrst_err", tx_err, 1'b0);
      check("mrst_ready", blk_ready, 1'b1);
      fb = n_flag;
      repeat (30) @(negedge clk);
      check("mrst_no_flag", n_flag - fb, 0);
      check("mrst_idle", busy, 1'b0);
      rb = rx_q.size(); db = n_done;
      exp_q.delete();
      push_blk(1'b0, 128'h0badc0de_deadbeef_cafef00d_12345678);
      wait_done("mrst_new_done", db + 1, 3000);
      cmp_frames("mrst_new", rb);

      // Random traffic against the frame model.
      rb = rx_q.size(); fb = n_flag; db = n_done; eb = n_err;
      exp_q.delete();
      for (int i = 0; i < 6; i++) begin
         repeat ($urandom_range(0, 15)) @(negedge clk);
         resp_delay = $urandom_range(1, 6);
         push_blk(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom});
      end
      wait_done("rnd_done", db + 6, 6000);
      check("rnd_flags", n_flag - fb, 108);
      check("rnd_err", n_err - eb, 0);
      cmp_frames("rnd", rb);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/aes_tx_framer.md
Name: aes_tx_framer

Overview:
- Output-side stage between the AES result producer and the UART byte transmitter.
- Accepts 128-bit result blocks (cipher or plain) through a valid/ready handshake and buffers them in a small FIFO.
- Serialises each block as an 18-byte frame: type tag, 16 data bytes MSB first, XOR checksum.
- Drives the transmitter's pi_data/pi_flag interface and paces bytes on its tx_end pulse, with a per-byte timeout.

Parameters:
- DEPTH, 2, FIFO entries (≥1); each entry is 129 bits (type + data).
- TX_TIMEOUT, 'd100_000, clock cycles allowed in WAIT for tx_end before the frame is aborted. Must exceed one byte time (~4340 cycles at 115200 baud / 50 MHz).
- TAG_CIPHER, 8'h43, tag byte for cipher blocks ("C").
- TAG_PLAIN, 8'h50, tag byte for plain blocks ("P").

Ports:
- clk  in  1  system clock; the single clock domain.
- rst_n  in  1  synchronous, active-low reset.
- blk_valid  in  1  result block offered.
- blk_ready  out  1  FIFO can accept; combinational = (count != DEPTH).
- blk_data  in  128  result block; byte [127:120] is sent first.
- blk_type  in  1  0 = cipher, 1 = plain.
- tx_data  out  8  byte to the UART transmitter; registered.
- tx_flag  out  1  one-cycle start pulse to the transmitter; registered.
- tx_end  in  1  one-cycle pulse from the transmitter when the byte finishes.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse after byte 17 completes.
- tx_err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (sampled on posedge clk while rst_n = 0):
  - FIFO emptied, count = 0, state = IDLE.
  - tx_data = 0, tx_flag = 0, frame_done = 0, tx_err = 0, byte index = 0, timeout counter = 0.
  - blk_ready reads 1 on the first cycle after reset.
  - Reset mid-frame discards the current frame and all buffered entries; no further tx_flag is issued.
- FIFO:
  - Push when blk_valid && blk_ready. Pop only on the LOAD→SEND edge.
  - Circular read/write pointers wrap modulo DEPTH.
  - Push and pop on the same edge: both happen and count is unchanged. When count = DEPTH, blk_ready = 0, so no push can occur.
  - Entries are emitted strictly in acceptance order.
- State machine, one transition per edge unless stated otherwise:
  - IDLE: if count > 0, go to LOAD; otherwise stay.
  - LOAD: latch the head entry into a 128-bit shift register and the type register; precompute chk = XOR of the 16 data bytes; index = 0; go to SEND.
  - SEND:
    - tx_flag = 1 for exactly this cycle.
    - tx_data = tag (index 0), data byte (index 1..16, taken from the shift register MSB, which then shifts left 8), or chk (index 17).
    - Clear the timeout counter; go to WAIT.
  - WAIT:
    - On tx_end: if index = 17, go to DONE; else index++ and go to SEND.
    - Else, if the timeout counter = TX_TIMEOUT-1: pulse tx_err, go to IDLE; the popped entry is lost.
    - Else, increment the timeout counter.
    - tx_end has priority over timeout on the same cycle.
  - DONE: frame_done = 1 for this cycle; go to IDLE.
- tx_end arriving in IDLE, LOAD, SEND or DONE is ignored.
- tx_data holds its last value between SEND cycles; tx_flag = 0 outside SEND.
- Latency:
  - Block accepted at edge E0 into an idle, empty block: IDLE→LOAD at E1, tx_flag high after E2.
  - With an instant transmitter, per-byte spacing is 2 cycles minimum (SEND, WAIT).
  - Back-to-back frames are separated by DONE + IDLE + LOAD (3 cycles) after the last tx_end.
- blk_data and blk_type are sampled only at the push edge; later changes do not affect a queued entry.

Test Plan:
- Cipher FIPS-197: blk_type = 0, blk_data = 128'h69c4e0d86a7b0430d8cdb78070b4c55a, transmitter model returns tx_end 10 cycles after each tx_flag.
  -> bytes 43, 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a, C9.
  -> exactly 18 tx_flag pulses, one frame_done, tx_err never asserted.
- Plain all-zero block: blk_type = 1, data = 0.
  -> bytes 50, sixteen 00, checksum 00.
  -> first tx_flag 2 edges after the accepting edge.
- Back-pressure: DEPTH = 2, offer blocks A, B, C on consecutive cycles with blk_valid held high.
  -> blk_ready = 0 while count = 2.
  -> C accepted only after A's pop.
  -> three frames in order A, B, C; 54 tx_flag pulses; no loss and no duplication.
- Timeout: TX_TIMEOUT = 64, transmitter never returns tx_end.
  -> single tx_flag (tag byte), tx_err pulse exactly 64 cycles after entering WAIT.
  -> busy falls; the next queued block then starts a fresh frame at index 0.
- Stray and simultaneous events:
  - tx_end injected in the SEND cycle -> ignored; index does not advance.
  - tx_end on the same cycle as timeout expiry -> treated as byte complete; no tx_err.
- Reset mid-frame: assert rst_n = 0 for 1 cycle after byte 5, with 1 entry queued.
  -> next cycle: all outputs 0, blk_ready = 1, count = 0.
  -> no further tx_flag until a new block is pushed.
